// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the R/I/J datapath: decodes IR in ID,
// latches the instruction class and drives latch enables, memory strobes and mux selects.
module cpu_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IR,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_en,
    output logic             ab_en,
    output logic             aluo_en,
    output logic             lmd_en,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_en,
    output logic [2:0]       stage,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_ILL
    } cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, dec_cls;
    logic [2:0]       aluop_q, dec_aluop;
    logic [1:0]       srcb_q, dec_srcb;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The all-zero word is the only R-type with funct 000000 that is accepted (NOP).
    always_comb begin
        dec_cls   = C_ILL;
        dec_aluop = 3'd0;
        dec_srcb  = 2'd0;
        case (IR[31:26])
            6'b000000: begin
                case (IR[5:0])
                    6'b100000: begin dec_cls = C_ALU; dec_aluop = 3'd0; end
                    6'b100010: begin dec_cls = C_ALU; dec_aluop = 3'd1; end
                    6'b100100: begin dec_cls = C_ALU; dec_aluop = 3'd2; end
                    6'b100101: begin dec_cls = C_ALU; dec_aluop = 3'd3; end
                    6'b101010: begin dec_cls = C_ALU; dec_aluop = 3'd4; end
                    6'b000000: begin
                        if (IR == 32'd0) begin
                            dec_cls = C_ALU;
                        end
                    end
                    default: dec_cls = C_ILL;
                endcase
            end
            6'b001000: begin dec_cls = C_ALU; dec_aluop = 3'd0; dec_srcb = 2'd1; end
            6'b001100: begin dec_cls = C_ALU; dec_aluop = 3'd2; dec_srcb = 2'd2; end
            6'b001101: begin dec_cls = C_ALU; dec_aluop = 3'd3; dec_srcb = 2'd2; end
            6'b100011: begin dec_cls = C_LW;  dec_aluop = 3'd0; dec_srcb = 2'd1; end
            6'b101011: begin dec_cls = C_SW;  dec_aluop = 3'd0; dec_srcb = 2'd1; end
            6'b000100: begin dec_cls = C_BEQ; dec_aluop = 3'd1; dec_srcb = 2'd0; end
            6'b000010: begin dec_cls = C_J; end
            default:   dec_cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  if (mem_ready) state_d = S_ID;
            S_ID:  state_d = (dec_cls == C_ILL) ? S_IF : S_EX;
            S_EX: begin
                case (cls_q)
                    C_LW, C_SW:  state_d = S_MEM;
                    C_ALU:       state_d = S_WB;
                    default:     state_d = S_IF;
                endcase
            end
            S_MEM: if (mem_ready) state_d = (cls_q == C_LW) ? S_WB : S_IF;
            S_WB:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            cls_q   <= C_ILL;
            aluop_q <= 3'd0;
            srcb_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_ID) begin
                cls_q   <= dec_cls;
                aluop_q <= dec_aluop;
                srcb_q  <= dec_srcb;
            end
        end
    end

    // Outputs are forced low for the whole time rst is high, so an abandoned store never strobes.
    always_comb begin
        pc_en       = 1'b0;
        ir_en       = 1'b0;
        ab_en       = 1'b0;
        aluo_en     = 1'b0;
        lmd_en      = 1'b0;
        pc_src      = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = 3'd0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        wb_en       = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        stage       = rst ? 3'd0 : state_q;
        retired_cnt = rst ? '0 : cnt_q;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_en    = mem_ready;
                    pc_en    = mem_ready;
                end
                S_ID: begin
                    ab_en   = 1'b1;
                    illegal = (dec_cls == C_ILL);
                end
                S_EX: begin
                    aluo_en   = 1'b1;
                    alu_op    = aluop_q;
                    alu_src_b = srcb_q;
                    if (cls_q == C_BEQ) begin
                        pc_src = 2'd1;
                        pc_en  = zero;
                        retire = 1'b1;
                    end else if (cls_q == C_J) begin
                        pc_src = 2'd2;
                        pc_en  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    if (cls_q == C_LW) begin
                        mem_read = 1'b1;
                        lmd_en   = mem_ready;
                    end else begin
                        mem_write = 1'b1;
                        retire    = mem_ready;
                    end
                end
                S_WB: begin
                    wb_en  = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: per-cycle comparison against a stage-list reference model,
// a table of directed instructions with hand-derived totals, a mid-store reset and random instructions.
module tb_cpu_seq_ctrl;

    localparam int CNT_W = 3;

    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_BEQ = 3;
    localparam int K_J   = 4;
    localparam int K_ILL = 5;

    logic             clk;
    logic             rst;
    logic [31:0]      IR;
    logic             zero;
    logic             mem_ready;
    logic             pc_en, ir_en, ab_en, aluo_en, lmd_en;
    logic [1:0]       pc_src, alu_src_b;
    logic [2:0]       alu_op;
    logic             mem_read, mem_write, wb_en;
    logic [2:0]       stage;
    logic             retire, illegal;
    logic [CNT_W-1:0] retired_cnt;

    cpu_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .IR(IR), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .ab_en(ab_en), .aluo_en(aluo_en), .lmd_en(lmd_en),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
        .stage(stage), .retire(retire), .illegal(illegal), .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             pcEn;
        logic             irEn;
        logic             abEn;
        logic             aluoEn;
        logic             lmdEn;
        logic [1:0]       pcSrc;
        logic [1:0]       srcB;
        logic [2:0]       aluOp;
        logic             memRd;
        logic             memWr;
        logic             wbEn;
        logic [2:0]       stg;
        logic             ret;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct {
        logic [31:0] ir;
        logic        z;
        int          ifS;
        int          memS;
        int          cyc;
        int          wb;
        int          ret;
        int          ill;
        int          pcEn;
    } vec_t;

    int total = 0;
    int bad = 0;
    int modelCnt = 0;
    int accCyc, accWb, accRet, accIll, accPcEn;

    // Reference decode straight from the instruction table: class plus the EX-stage ALU controls.
    function automatic void decodeRef(input logic [31:0] ir, output int kind,
                                      output logic [2:0] op, output logic [1:0] src);
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ir[31:26];
        fn = ir[5:0];
        kind = K_ILL;
        op = 3'd0;
        src = 2'd0;
        if (opc == 6'b000000) begin
            kind = K_ALU;
            if (fn == 6'b100000) op = 3'd0;
            else if (fn == 6'b100010) op = 3'd1;
            else if (fn == 6'b100100) op = 3'd2;
            else if (fn == 6'b100101) op = 3'd3;
            else if (fn == 6'b101010) op = 3'd4;
            else if (ir != 32'd0) kind = K_ILL;
        end
        else if (opc == 6'b001000) begin kind = K_ALU; src = 2'd1; end
        else if (opc == 6'b001100) begin kind = K_ALU; op = 3'd2; src = 2'd2; end
        else if (opc == 6'b001101) begin kind = K_ALU; op = 3'd3; src = 2'd2; end
        else if (opc == 6'b100011) begin kind = K_LW; src = 2'd1; end
        else if (opc == 6'b101011) begin kind = K_SW; src = 2'd1; end
        else if (opc == 6'b000100) begin kind = K_BEQ; op = 3'd1; end
        else if (opc == 6'b000010) kind = K_J;
    endfunction

    function automatic obs_t refOut(input int stg, input int kind, input logic [2:0] op,
                                    input logic [1:0] src, input logic z, input logic mr);
        obs_t o;
        o = '0;
        o.stg = 3'(stg);
        o.cnt = CNT_W'(modelCnt);
        case (stg)
            0: begin o.memRd = 1'b1; o.irEn = mr; o.pcEn = mr; end
            1: begin o.abEn = 1'b1; o.ill = (kind == K_ILL); end
            2: begin
                o.aluoEn = 1'b1;
                o.aluOp = op;
                o.srcB = src;
                if (kind == K_BEQ) begin o.pcSrc = 2'd1; o.pcEn = z; o.ret = 1'b1; end
                if (kind == K_J) begin o.pcSrc = 2'd2; o.pcEn = 1'b1; o.ret = 1'b1; end
            end
            3: begin
                if (kind == K_LW) begin o.memRd = 1'b1; o.lmdEn = mr; end
                else begin o.memWr = 1'b1; o.ret = mr; end
            end
            4: begin o.wbEn = 1'b1; o.ret = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sampleDut();
        obs_t a;
        a.pcEn = pc_en; a.irEn = ir_en; a.abEn = ab_en; a.aluoEn = aluo_en; a.lmdEn = lmd_en;
        a.pcSrc = pc_src; a.srcB = alu_src_b; a.aluOp = alu_op;
        a.memRd = mem_read; a.memWr = mem_write; a.wbEn = wb_en;
        a.stg = stage; a.ret = retire; a.ill = illegal; a.cnt = retired_cnt;
        return a;
    endfunction

    task automatic applyStimulus(input logic [31:0] ir, input logic z, input logic mr);
        IR = ir;
        zero = z;
        mem_ready = mr;
    endtask

    task automatic checkOutput(input string name, input obs_t expv);
        obs_t act;
        act = sampleDut();
        total++;
        accCyc++;
        accWb += int'(act.wbEn);
        accRet += int'(act.ret);
        accIll += int'(act.ill);
        accPcEn += int'(act.pcEn);
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, expv);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, act, expv);
        end
    endtask

    // One clock: drive just after the rising edge, compare on the falling edge.
    task automatic stepCheck(input string tag, input logic [31:0] ir, input logic z,
                             input logic mr, input int stg);
        int kind;
        logic [2:0] op;
        logic [1:0] src;
        obs_t e;
        decodeRef(ir, kind, op, src);
        e = refOut(stg, kind, op, src, z, mr);
        applyStimulus(ir, z, mr);
        @(negedge clk);
        checkOutput($sformatf("%s.s%0d", tag, stg), e);
        if (e.ret) modelCnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input string tag, input logic [31:0] ir, input logic z,
                            input int ifS, input int memS);
        int kind;
        logic [2:0] op;
        logic [1:0] src;
        int stages[$];
        decodeRef(ir, kind, op, src);
        case (kind)
            K_ALU:   stages = '{0, 1, 2, 4};
            K_LW:    stages = '{0, 1, 2, 3, 4};
            K_SW:    stages = '{0, 1, 2, 3};
            K_ILL:   stages = '{0, 1};
            default: stages = '{0, 1, 2};
        endcase
        accCyc = 0; accWb = 0; accRet = 0; accIll = 0; accPcEn = 0;
        foreach (stages[si]) begin
            int stg;
            int n;
            stg = stages[si];
            n = (stg == 0) ? ifS : ((stg == 3) ? memS : 0);
            for (int k = 0; k <= n; k++) begin
                logic mr;
                if (stg == 0 || stg == 3) mr = (k == n);
                else mr = 1'($urandom_range(0, 1));
                stepCheck(tag, ir, z, mr, stg);
            end
        end
    endtask

    function automatic logic [31:0] randIr();
        logic [5:0] ops[10];
        logic [5:0] fns[7];
        logic [31:0] r;
        int p;
        ops = '{6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b101010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000111};
        r = $urandom;
        p = $urandom_range(0, 10);
        if (p < 10) r[31:26] = ops[p];
        if (r[31:26] == 6'b000000) r[5:0] = fns[$urandom_range(0, 6)];
        if ($urandom_range(0, 7) == 0) r = 32'd0;
        return r;
    endfunction

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{32'h00000020, 1'b0, 0, 0, 4, 1, 1, 0, 1};
        vecs[1]  = '{32'h8C000000, 1'b0, 0, 2, 7, 1, 1, 0, 1};
        vecs[2]  = '{32'hAC000000, 1'b0, 0, 0, 4, 0, 1, 0, 1};
        vecs[3]  = '{32'h30000000, 1'b0, 0, 0, 4, 1, 1, 0, 1};
        vecs[4]  = '{32'h10000000, 1'b1, 0, 0, 3, 0, 1, 0, 2};
        vecs[5]  = '{32'h10000000, 1'b0, 0, 0, 3, 0, 1, 0, 1};
        vecs[6]  = '{32'h08000000, 1'b0, 0, 0, 3, 0, 1, 0, 2};
        vecs[7]  = '{32'hA8000000, 1'b0, 0, 0, 2, 0, 0, 1, 1};
        vecs[8]  = '{32'h00000000, 1'b0, 0, 0, 4, 1, 1, 0, 1};
        vecs[9]  = '{32'h34000000, 1'b0, 1, 0, 5, 1, 1, 0, 1};
        vecs[10] = '{32'h00010000, 1'b0, 0, 0, 2, 0, 0, 1, 1};
        vecs[11] = '{32'h00000022, 1'b0, 2, 0, 6, 1, 1, 0, 1};
        vecs[12] = '{32'h0000002A, 1'b0, 0, 0, 4, 1, 1, 0, 1};
        vecs[13] = '{32'h20000000, 1'b0, 0, 0, 4, 1, 1, 0, 1};
        vecs[14] = '{32'hAC000000, 1'b0, 1, 1, 6, 0, 1, 0, 1};

        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", obs_t'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 15; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            runInstr(tag, vecs[v].ir, vecs[v].z, vecs[v].ifS, vecs[v].memS);
            checkVal({tag, ".cycles"}, accCyc, vecs[v].cyc);
            checkVal({tag, ".wb"}, accWb, vecs[v].wb);
            checkVal({tag, ".retire"}, accRet, vecs[v].ret);
            checkVal({tag, ".illegal"}, accIll, vecs[v].ill);
            checkVal({tag, ".pcEn"}, accPcEn, vecs[v].pcEn);
        end

        // Store abandoned by reset while MEM is stalled.
        stepCheck("swRst", 32'hAC000000, 1'b0, 1'b1, 0);
        stepCheck("swRst", 32'hAC000000, 1'b0, 1'b0, 1);
        stepCheck("swRst", 32'hAC000000, 1'b0, 1'b1, 2);
        stepCheck("swRst", 32'hAC000000, 1'b0, 1'b0, 3);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstMidMem", obs_t'(0));
        modelCnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        runInstr("afterRst", 32'h00000020, 1'b0, 1, 0);
        checkVal("afterRst.retire", accRet, 1);

        for (int i = 0; i < 60; i++) begin
            runInstr($sformatf("rnd%0d", i), randIr(), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle sequencing controller for the R/I/J CPU datapath. Holds the instruction-stage FSM (IF, ID, EX, MEM, WB), decodes the latched IR, and drives the latch enables, memory strobes and mux selects for PC, IR, A/B, ALUo, LMD and the write-back register stage. It stalls on memory handshakes, counts retired instructions and flags illegal encodings.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock; everything updates on rising edge
- rst  in  1  synchronous, active-high reset
- IR  in  32  instruction register contents (valid from ID onward)
- zero  in  1  ALU zero flag (valid in EX)
- mem_ready  in  1  memory handshake; used in IF (fetch) and MEM (data)
- pc_en, ir_en, ab_en, aluo_en, lmd_en  out  1 each  datapath latch enables
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- alu_src_b  out  2  0 = B, 1 = sign-ext imm16, 2 = zero-ext imm16
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
- mem_read, mem_write  out  1  memory strobes
- wb_en  out  1  write-back stage strobe to WBReg
- stage  out  3  0 IF, 1 ID, 2 EX, 3 MEM, 4 WB
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse on undecodable instruction
- retired_cnt  out  CNT_W  retired-instruction count

## Operation
- Decode (from IR): op 000000 with funct 100000/100010/100100/100101/101010 → R add/sub/and/or/slt; funct 000000 with IR == 0 → NOP (R-type, retires, wb_en still pulses, rd = 0); other funct → illegal. op 001000 addi, 001100 andi, 001101 ori, 100011 lw, 101011 sw, 000100 beq, 000010 j; any other op → illegal.
- Sequences: R/addi/andi/ori: IF ID EX WB. lw: IF ID EX MEM WB. sw: IF ID EX MEM. beq, j: IF ID EX.
- IF: mem_read = 1; stays in IF while mem_ready = 0; on mem_ready = 1, ir_en = 1, pc_en = 1, pc_src = 0, next ID.
- ID: ab_en = 1. Legal → EX. Illegal → illegal = 1, next IF, no retire.
- EX: aluo_en = 1; alu_op/alu_src_b per decode (addi/lw/sw: add, src 1; andi: and, src 2; ori: or, src 2; beq: sub, src 0). beq: pc_src = 1, pc_en = zero. j: pc_src = 2, pc_en = 1. beq/j retire here and return to IF.
- MEM: lw: mem_read = 1, lmd_en = mem_ready. sw: mem_write = 1. Held in MEM, strobes held, until mem_ready = 1. sw retires on exit.
- WB: wb_en = 1 for exactly one cycle, retire = 1, next IF.
- Outputs are Moore-decoded from state and latched decode, except pc_en/ir_en/lmd_en/exit, which are gated by mem_ready/zero in the same cycle.
- retired_cnt increments by 1 on each retire, wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: while rst = 1, every output is 0 (stage = 0, retired_cnt = 0). State is IF on the first cycle after deassertion.
- Reset mid-instruction: abandoned on the next edge. No wb_en, mem_write or retire for it. A held mem_write is dropped.
- Latency with mem_ready always 1: R/I-ALU 4 cycles, lw 5, sw 4, beq/j 3, illegal 2.
- Each mem_ready = 0 cycle in IF or MEM adds one cycle. Enables never assert during stall cycles.
- Retire and illegal are never high in the same cycle. At most one pc_en per stage.

## Test plan
- Reset then add (IR = 0x00000020), mem_ready = 1 → stage 0,1,2,4; wb_en high only in the 4th cycle; alu_op = 0, alu_src_b = 0; retired_cnt = 1.
- lw (op 100011) with mem_ready low for 2 cycles in MEM → MEM lasts 3 cycles, mem_read held, lmd_en only in the last; wb_en follows; total 7 cycles.
- sw (op 101011) → no wb_en; mem_write high in MEM; retire on MEM exit; andi → alu_src_b = 2, alu_op = 2.
- beq with zero = 1 then zero = 0 → pc_en with pc_src = 1 only in the first EX; j → pc_src = 2, pc_en = 1; each 3 cycles.
- IR = 0xA8000000 (op 101010) → illegal pulse in ID, back to IF, retired_cnt unchanged.
- rst asserted during MEM of sw with mem_ready = 0 → next cycle all outputs 0, retired_cnt = 0; after release, IF.
